// File: rtl/seg7_pkg.sv
// Seven-segment constants (active-low {a,b,c,d,e,f,g}) and BCD helper functions
// shared by the step counter and its arithmetic sub-module.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MAX_DIGITS = 8;

    // Non-decimal codes fall back to BLANK so every input has a defined pattern.
    function automatic logic [6:0] seg7Encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] intToBcd(input int value);
        logic [31:0] bcd;
        int          rest;
        bcd  = '0;
        rest = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rest % 10);
            rest          = rest / 10;
        end
        return bcd;
    endfunction

    function automatic int pow10(input int exponent);
        int result;
        result = 1;
        for (int i = 0; i < exponent; i++) begin
            result = result * 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_step_adder.sv
// Combinational +/-STEP arithmetic on a packed BCD count, with decimal carry/borrow
// and wrap detection against the 0..MAX range.
module bcd_step_adder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int STEP   = 2,
    parameter int MAX    = 14
) (
    input  logic [4*DIGITS-1:0] count_i,
    input  logic                down_i,
    output logic [4*DIGITS-1:0] next_o,
    output logic                wrap_o
);

    localparam int                  WIDTH       = 4 * DIGITS;
    localparam logic [31:0]         MAX_BCD_ALL = intToBcd(MAX);
    localparam logic [WIDTH-1:0]    MAX_BCD     = MAX_BCD_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    STEP_BCD    = WIDTH'(STEP);
    localparam logic [4:0]          STEP5       = 5'(STEP);

    logic [WIDTH-1:0] sumBcd;
    logic [WIDTH-1:0] diffBcd;
    logic [3:0]       digitIn;
    logic [4:0]       addend;
    logic [4:0]       digitSum;
    logic [4:0]       subtrahend;
    logic             carry;
    logic             borrow;
    logic             upOk;
    logic             downOk;

    // Both directions are computed every cycle; down_i only picks the result.
    // A carry out of the top digit means the sum left the representable range.
    always_comb begin
        sumBcd     = '0;
        diffBcd    = '0;
        digitIn    = '0;
        addend     = '0;
        digitSum   = '0;
        subtrahend = '0;
        carry      = 1'b0;
        borrow     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digitIn  = count_i[4*i +: 4];
            addend   = (i == 0) ? STEP5 : 5'd0;
            digitSum = {1'b0, digitIn} + addend + {4'd0, carry};
            if (digitSum > 5'd9) begin
                sumBcd[4*i +: 4] = 4'(digitSum - 5'd10);
                carry            = 1'b1;
            end else begin
                sumBcd[4*i +: 4] = digitSum[3:0];
                carry            = 1'b0;
            end
            subtrahend = addend + {4'd0, borrow};
            if ({1'b0, digitIn} >= subtrahend) begin
                diffBcd[4*i +: 4] = 4'({1'b0, digitIn} - subtrahend);
                borrow            = 1'b0;
            end else begin
                diffBcd[4*i +: 4] = 4'({1'b0, digitIn} + 5'd10 - subtrahend);
                borrow            = 1'b1;
            end
        end
        upOk   = !carry && (sumBcd <= MAX_BCD);
        downOk = (count_i >= STEP_BCD);
        if (down_i) begin
            next_o = downOk ? diffBcd : MAX_BCD;
            wrap_o = !downOk;
        end else begin
            next_o = upOk ? sumBcd : '0;
            wrap_o = !upOk;
        end
    end

endmodule

// File: rtl/bcd_step_counter_display.sv
// BCD up/down step counter with load validation and a registered seven-segment
// display that supports hold, blanking and optional leading-zero blanking.
module bcd_step_counter_display
    import seg7_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int STEP   = 2,
    parameter int MAX    = 14,
    parameter int LZB    = 0
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                down_i,
    input  logic                load_i,
    input  logic [4*DIGITS-1:0] load_value_i,
    input  logic                hold_i,
    input  logic                blanking_i,
    output logic [7*DIGITS-1:0] display_o,
    output logic [4*DIGITS-1:0] count_o,
    output logic                wrap_o,
    output logic                load_err_o
);

    localparam int               WIDTH       = 4 * DIGITS;
    localparam logic [31:0]      MAX_BCD_ALL = intToBcd(MAX);
    localparam logic [WIDTH-1:0] MAX_BCD     = MAX_BCD_ALL[WIDTH-1:0];
    localparam logic [6:0]       STEP7       = 7'(STEP);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("DIGITS must be in 1..8");
    end
    if (STEP < 1 || STEP > 9) begin : g_bad_step
        $error("STEP must be in 1..9");
    end
    if (MAX < 0 || (MAX % STEP) != 0 || MAX >= pow10(DIGITS)) begin : g_bad_max
        $error("MAX must be a multiple of STEP and below 10**DIGITS");
    end

    logic [WIDTH-1:0]    count_q,    count_d;
    logic [7*DIGITS-1:0] display_q,  display_d;
    logic                wrap_q,     wrap_d;
    logic                loadErr_q,  loadErr_d;

    logic [WIDTH-1:0]    adderNext;
    logic                adderWrap;
    logic                digitsOk;
    logic [6:0]          remainder;
    logic                loadValid;

    bcd_step_adder #(
        .DIGITS (DIGITS),
        .STEP   (STEP),
        .MAX    (MAX)
    ) u_adder (
        .count_i (count_q),
        .down_i  (down_i),
        .next_o  (adderNext),
        .wrap_o  (adderWrap)
    );

    // Divisibility is checked digit by digit from the top, carrying the running
    // remainder, so no BCD-to-binary conversion is needed. The range compare is
    // only meaningful once every digit is known to be decimal.
    always_comb begin
        digitsOk  = 1'b1;
        remainder = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (load_value_i[4*i +: 4] > 4'd9) begin
                digitsOk = 1'b0;
            end
            remainder = (remainder * 7'd10 + {3'd0, load_value_i[4*i +: 4]}) % STEP7;
        end
        loadValid = digitsOk && (load_value_i <= MAX_BCD) && (remainder == 7'd0);
    end

    // Load beats enable even when the load is rejected.
    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        loadErr_d = loadErr_q;
        if (load_i) begin
            if (loadValid) begin
                count_d = load_value_i;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (enable_i) begin
            count_d = adderNext;
            wrap_d  = adderWrap;
        end
    end

    // The display renders the pre-edge count, so it trails count by one cycle.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] digit;
        logic       suppress;
        assign digit    = count_q[4*g +: 4];
        assign suppress = (LZB != 0) && (g != 0) && (count_q[WIDTH-1:4*g] == '0);
        assign display_d[7*g +: 7] = blanking_i ? SEG_BLANK            :
                                     hold_i     ? display_q[7*g +: 7]  :
                                     suppress   ? SEG_BLANK            :
                                                  seg7Encode(digit);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_q   <= '0;
            display_q <= {DIGITS{SEG_BLANK}};
            wrap_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            display_q <= display_d;
            wrap_q    <= wrap_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign count_o    = count_q;
    assign display_o  = display_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = loadErr_q;

endmodule
